// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU-side requesters, the memory arbiter and the
// asynchronous memory port. The slave modport is the arbiter's view; the
// master modport is the view of whatever drives requests and memory data.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              fetchReq;
  logic [ADDR_W-1:0] fetchAddr;
  logic              fetchAck;
  logic [DATA_W-1:0] fetchData;

  logic              dataReq;
  logic              dataWe;
  logic [ADDR_W-1:0] dataAddr;
  logic [DATA_W-1:0] dataWData;
  logic              dataAck;
  logic [DATA_W-1:0] dataRData;

  logic [ADDR_W-1:0] memAddr;
  logic              memRe;
  logic              memWe;
  logic [DATA_W-1:0] memWBus;
  logic [DATA_W-1:0] memRBus;

  modport slave (
    input  fetchReq, fetchAddr, dataReq, dataWe, dataAddr, dataWData, memRBus,
    output fetchAck, fetchData, dataAck, dataRData, memAddr, memRe, memWe, memWBus
  );

  modport master (
    output fetchReq, fetchAddr, dataReq, dataWe, dataAddr, dataWData, memRBus,
    input  fetchAck, fetchData, dataAck, dataRData, memAddr, memRe, memWe, memWBus
  );
endinterface

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one asynchronous memory port between instruction
// fetch (read-only) and load/store (read/write). Requests are only looked at
// in IDLE; the winner's address and write data are captured on the grant edge
// so requester inputs may change freely until the next IDLE. Under contention
// the requester that was not granted last wins, which alternates grants.
module mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int READ_WAIT = 1
) (
  input  logic           clk,
  input  logic           rstN,
  mem_arbiter_if.slave   bus
);

  localparam int CNT_W = (READ_WAIT < 2) ? 1 : $clog2(READ_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(READ_WAIT);
  localparam logic [CNT_W-1:0] WAIT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    ACK       = 3'd2,
    WR_SETUP  = 3'd3,
    WR_STROBE = 3'd4,
    WR_HOLD   = 3'd5
  } state_e;

  state_e            state_r;
  state_e            stateNext_s;
  logic              grantFetch_s;
  logic              grantData_s;
  logic              grantAny_s;
  logic              lastGrantFetch_r;
  logic              ownerFetch_r;
  logic [CNT_W-1:0]  waitCnt_r;

  logic [ADDR_W-1:0] memAddr_r;
  logic [DATA_W-1:0] memWBus_r;
  logic              memRe_r;
  logic              memWe_r;
  logic              fetchAck_r;
  logic              dataAck_r;
  logic [DATA_W-1:0] fetchData_r;
  logic [DATA_W-1:0] dataRData_r;

  // Arbitration and next-state decode; a tie goes to whoever was not granted last.
  always_comb begin
    grantFetch_s = bus.fetchReq && (!bus.dataReq || !lastGrantFetch_r);
    grantData_s  = bus.dataReq && !grantFetch_s;
    grantAny_s   = grantFetch_s || grantData_s;
    stateNext_s  = state_r;
    case (state_r)
      IDLE: begin
        if (grantFetch_s) begin
          stateNext_s = READ;
        end else if (grantData_s) begin
          stateNext_s = bus.dataWe ? WR_SETUP : READ;
        end else begin
          stateNext_s = IDLE;
        end
      end
      READ: begin
        if (waitCnt_r == WAIT_LAST) begin
          stateNext_s = ACK;
        end else begin
          stateNext_s = READ;
        end
      end
      ACK:       stateNext_s = IDLE;
      WR_SETUP:  stateNext_s = WR_STROBE;
      WR_STROBE: stateNext_s = WR_HOLD;
      WR_HOLD:   stateNext_s = IDLE;
      default:   stateNext_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Strobes and acks are decoded from the next state so they are registered outputs.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      memRe_r    <= 1'b0;
      memWe_r    <= 1'b0;
      fetchAck_r <= 1'b0;
      dataAck_r  <= 1'b0;
    end else begin
      memRe_r    <= (stateNext_s == READ);
      memWe_r    <= (stateNext_s == WR_STROBE);
      fetchAck_r <= (stateNext_s == ACK) && ownerFetch_r;
      dataAck_r  <= ((stateNext_s == ACK) && !ownerFetch_r) || (stateNext_s == WR_HOLD);
    end
  end

  // Grant bookkeeping, read wait counter and address/write-data capture.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      lastGrantFetch_r <= 1'b0;
      ownerFetch_r     <= 1'b0;
      waitCnt_r        <= '0;
      memAddr_r        <= '0;
      memWBus_r        <= '0;
    end else if ((state_r == IDLE) && grantAny_s) begin
      lastGrantFetch_r <= grantFetch_s;
      ownerFetch_r     <= grantFetch_s;
      waitCnt_r        <= WAIT_ONE;
      memAddr_r        <= grantFetch_s ? bus.fetchAddr : bus.dataAddr;
      if (grantData_s && bus.dataWe) begin
        memWBus_r <= bus.dataWData;
      end else begin
        memWBus_r <= memWBus_r;
      end
    end else if (state_r == READ) begin
      waitCnt_r <= waitCnt_r + WAIT_ONE;
    end else begin
      waitCnt_r <= waitCnt_r;
    end
  end

  // Read data capture on the last READ edge; each requester keeps its own copy.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      fetchData_r <= '0;
      dataRData_r <= '0;
    end else if ((state_r == READ) && (stateNext_s == ACK)) begin
      if (ownerFetch_r) begin
        fetchData_r <= bus.memRBus;
      end else begin
        dataRData_r <= bus.memRBus;
      end
    end else begin
      fetchData_r <= fetchData_r;
      dataRData_r <= dataRData_r;
    end
  end

  assign bus.memAddr   = memAddr_r;
  assign bus.memWBus   = memWBus_r;
  assign bus.memRe     = memRe_r;
  assign bus.memWe     = memWe_r;
  assign bus.fetchAck  = fetchAck_r;
  assign bus.dataAck   = dataAck_r;
  assign bus.fetchData = fetchData_r;
  assign bus.dataRData = dataRData_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a cycle-by-cycle vector table from reset, then two
// hand-written sequences for write strobe timing and read ack latency.
// A small asynchronous memory model answers reads and latches writes.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rstN;
  int   checks = 0;
  int   fails  = 0;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_WAIT(1)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on an edge where memWe is high.
  logic [15:0] mem [0:63];
  logic        memInit = 1'b0;
  always @(posedge clk) begin
    if (!memInit) begin
      for (int k = 0; k < 64; k++) mem[k] <= 16'h0000;
      mem[1]  <= 16'h1234;
      mem[16] <= 16'hAAAA;
      mem[32] <= 16'h0BBB;
      memInit <= 1'b1;
    end else if (bus.memWe) begin
      mem[bus.memAddr[5:0]] <= bus.memWBus;
    end
  end
  assign bus.memRBus = mem[bus.memAddr[5:0]];

  typedef struct packed {
    logic        rst;
    logic        fr;
    logic [15:0] fa;
    logic        dr;
    logic        dw;
    logic [15:0] da;
    logic [15:0] dwd;
    logic        eRe;
    logic        eWe;
    logic [15:0] eAddr;
    logic [15:0] eWBus;
    logic        eFAck;
    logic        eDAck;
    logic [15:0] eFData;
    logic [15:0] eDData;
  } vec_t;

  function automatic vec_t mk(logic rst, logic fr, logic [15:0] fa, logic dr, logic dw,
                              logic [15:0] da, logic [15:0] dwd, logic eRe, logic eWe,
                              logic [15:0] eAddr, logic [15:0] eWBus, logic eFAck,
                              logic eDAck, logic [15:0] eFData, logic [15:0] eDData);
    vec_t v;
    v.rst = rst; v.fr = fr; v.fa = fa; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
    v.eRe = eRe; v.eWe = eWe; v.eAddr = eAddr; v.eWBus = eWBus;
    v.eFAck = eFAck; v.eDAck = eDAck; v.eFData = eFData; v.eDData = eDData;
    return v;
  endfunction

  task automatic chk(input string name, input int step, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  localparam int NV = 36;
  vec_t tbl [NV];

  int   weCnt;
  int   reCnt;
  int   cyc;
  logic seen;

  initial begin
    // rst fr  fa      dr  dw  da      dwd       Re  We  addr    wbus      fA  dA  fdata     ddata
    tbl[0]  = mk(0, 1, 16'h1, 0, 0, 16'h0,  16'h0,    0, 0, 16'h0,  16'h0,    0, 0, 16'h0,    16'h0);
    tbl[1]  = mk(0, 1, 16'h1, 0, 0, 16'h0,  16'h0,    0, 0, 16'h0,  16'h0,    0, 0, 16'h0,    16'h0);
    tbl[2]  = mk(0, 1, 16'h1, 0, 0, 16'h0,  16'h0,    0, 0, 16'h0,  16'h0,    0, 0, 16'h0,    16'h0);
    tbl[3]  = mk(1, 1, 16'h1, 0, 0, 16'h0,  16'h0,    1, 0, 16'h1,  16'h0,    0, 0, 16'h0,    16'h0);
    tbl[4]  = mk(1, 0, 16'h1, 0, 0, 16'h0,  16'h0,    0, 0, 16'h1,  16'h0,    1, 0, 16'h1234, 16'h0);
    tbl[5]  = mk(1, 0, 16'h1, 0, 0, 16'h0,  16'h0,    0, 0, 16'h1,  16'h0,    0, 0, 16'h1234, 16'h0);
    tbl[6]  = mk(1, 0, 16'h0, 1, 1, 16'h1,  16'h0237, 0, 0, 16'h1,  16'h0237, 0, 0, 16'h1234, 16'h0);
    tbl[7]  = mk(1, 0, 16'h0, 0, 1, 16'h1,  16'h0237, 0, 1, 16'h1,  16'h0237, 0, 0, 16'h1234, 16'h0);
    tbl[8]  = mk(1, 0, 16'h0, 0, 0, 16'h0,  16'h0,    0, 0, 16'h1,  16'h0237, 0, 1, 16'h1234, 16'h0);
    tbl[9]  = mk(1, 0, 16'h0, 0, 0, 16'h0,  16'h0,    0, 0, 16'h1,  16'h0237, 0, 0, 16'h1234, 16'h0);
    tbl[10] = mk(1, 0, 16'h0, 1, 0, 16'h1,  16'h0,    1, 0, 16'h1,  16'h0237, 0, 0, 16'h1234, 16'h0);
    tbl[11] = mk(1, 0, 16'h0, 0, 0, 16'h1,  16'h0,    0, 0, 16'h1,  16'h0237, 0, 1, 16'h1234, 16'h0237);
    tbl[12] = mk(1, 0, 16'h0, 0, 0, 16'h0,  16'h0,    0, 0, 16'h1,  16'h0237, 0, 0, 16'h1234, 16'h0237);
    tbl[13] = mk(1, 0, 16'h0, 1, 0, 16'h10, 16'h0,    1, 0, 16'h10, 16'h0237, 0, 0, 16'h1234, 16'h0237);
    tbl[14] = mk(1, 0, 16'h0, 1, 0, 16'h20, 16'h0,    0, 0, 16'h10, 16'h0237, 0, 1, 16'h1234, 16'hAAAA);
    tbl[15] = mk(1, 0, 16'h0, 0, 0, 16'h20, 16'h0,    0, 0, 16'h10, 16'h0237, 0, 0, 16'h1234, 16'hAAAA);
    tbl[16] = mk(0, 1, 16'h1, 1, 0, 16'h20, 16'h0,    0, 0, 16'h0,  16'h0,    0, 0, 16'h0,    16'h0);
    tbl[17] = mk(1, 1, 16'h1, 1, 0, 16'h20, 16'h0,    1, 0, 16'h1,  16'h0,    0, 0, 16'h0,    16'h0);
    tbl[18] = mk(1, 1, 16'h1, 1, 0, 16'h20, 16'h0,    0, 0, 16'h1,  16'h0,    1, 0, 16'h0237, 16'h0);
    tbl[19] = mk(1, 1, 16'h1, 1, 0, 16'h20, 16'h0,    0, 0, 16'h1,  16'h0,    0, 0, 16'h0237, 16'h0);
    tbl[20] = mk(1, 1, 16'h1, 1, 0, 16'h20, 16'h0,    1, 0, 16'h20, 16'h0,    0, 0, 16'h0237, 16'h0);
    tbl[21] = mk(1, 1, 16'h1, 1, 0, 16'h20, 16'h0,    0, 0, 16'h20, 16'h0,    0, 1, 16'h0237, 16'h0BBB);
    tbl[22] = mk(1, 1, 16'h1, 1, 0, 16'h20, 16'h0,    0, 0, 16'h20, 16'h0,    0, 0, 16'h0237, 16'h0BBB);
    tbl[23] = mk(1, 1, 16'h1, 1, 0, 16'h20, 16'h0,    1, 0, 16'h1,  16'h0,    0, 0, 16'h0237, 16'h0BBB);
    tbl[24] = mk(1, 1, 16'h1, 1, 0, 16'h20, 16'h0,    0, 0, 16'h1,  16'h0,    1, 0, 16'h0237, 16'h0BBB);
    tbl[25] = mk(1, 1, 16'h1, 1, 0, 16'h20, 16'h0,    0, 0, 16'h1,  16'h0,    0, 0, 16'h0237, 16'h0BBB);
    tbl[26] = mk(1, 1, 16'h1, 1, 0, 16'h20, 16'h0,    1, 0, 16'h20, 16'h0,    0, 0, 16'h0237, 16'h0BBB);
    tbl[27] = mk(1, 1, 16'h1, 1, 0, 16'h20, 16'h0,    0, 0, 16'h20, 16'h0,    0, 1, 16'h0237, 16'h0BBB);
    tbl[28] = mk(1, 0, 16'h1, 0, 0, 16'h20, 16'h0,    0, 0, 16'h20, 16'h0,    0, 0, 16'h0237, 16'h0BBB);
    tbl[29] = mk(1, 0, 16'h0, 1, 1, 16'h2,  16'h00FF, 0, 0, 16'h2,  16'h00FF, 0, 0, 16'h0237, 16'h0BBB);
    tbl[30] = mk(1, 0, 16'h0, 0, 1, 16'h2,  16'h00FF, 0, 1, 16'h2,  16'h00FF, 0, 0, 16'h0237, 16'h0BBB);
    tbl[31] = mk(0, 0, 16'h0, 0, 0, 16'h0,  16'h0,    0, 0, 16'h0,  16'h0,    0, 0, 16'h0,    16'h0);
    tbl[32] = mk(1, 0, 16'h0, 0, 0, 16'h0,  16'h0,    0, 0, 16'h0,  16'h0,    0, 0, 16'h0,    16'h0);
    tbl[33] = mk(1, 1, 16'h2, 0, 0, 16'h0,  16'h0,    1, 0, 16'h2,  16'h0,    0, 0, 16'h0,    16'h0);
    tbl[34] = mk(1, 0, 16'h2, 0, 0, 16'h0,  16'h0,    0, 0, 16'h2,  16'h0,    1, 0, 16'h00FF, 16'h0);
    tbl[35] = mk(1, 0, 16'h2, 0, 0, 16'h0,  16'h0,    0, 0, 16'h2,  16'h0,    0, 0, 16'h00FF, 16'h0);

    for (int i = 0; i < NV; i++) begin
      rstN          = tbl[i].rst;
      bus.fetchReq  = tbl[i].fr;
      bus.fetchAddr = tbl[i].fa;
      bus.dataReq   = tbl[i].dr;
      bus.dataWe    = tbl[i].dw;
      bus.dataAddr  = tbl[i].da;
      bus.dataWData = tbl[i].dwd;
      @(posedge clk);
      #1;
      chk("memRe",     i, {15'd0, bus.memRe},    {15'd0, tbl[i].eRe});
      chk("memWe",     i, {15'd0, bus.memWe},    {15'd0, tbl[i].eWe});
      chk("memAddr",   i, bus.memAddr,           tbl[i].eAddr);
      chk("memWBus",   i, bus.memWBus,           tbl[i].eWBus);
      chk("fetchAck",  i, {15'd0, bus.fetchAck}, {15'd0, tbl[i].eFAck});
      chk("dataAck",   i, {15'd0, bus.dataAck},  {15'd0, tbl[i].eDAck});
      chk("fetchData", i, bus.fetchData,         tbl[i].eFData);
      chk("dataRData", i, bus.dataRData,         tbl[i].eDData);
      chk("dualAck",   i, {15'd0, bus.fetchAck & bus.dataAck}, 16'd0);
      chk("dualStrobe", i, {15'd0, bus.memRe & bus.memWe}, 16'd0);
    end

    // Store 0x1357 to address 3 with dataReq held until the ack.
    bus.dataReq   = 1'b1;
    bus.dataWe    = 1'b1;
    bus.dataAddr  = 16'h0003;
    bus.dataWData = 16'h1357;
    weCnt = 0;
    reCnt = 0;
    seen  = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (bus.memWe) weCnt++;
      if (bus.memRe) reCnt++;
      if (bus.dataAck) seen = 1'b1;
    end
    chk("wrAckSeen",   100, {15'd0, seen}, 16'd1);
    chk("wrStrobeLen", 100, 16'(weCnt), 16'd1);
    chk("wrNoRead",    100, 16'(reCnt), 16'd0);
    chk("wrHoldAddr",  100, bus.memAddr, 16'h0003);
    chk("wrHoldData",  100, bus.memWBus, 16'h1357);
    bus.dataReq = 1'b0;
    @(posedge clk);
    #1;
    chk("wrAckPulse", 101, {15'd0, bus.dataAck}, 16'd0);

    // Fetch it back; ack expected on the second edge after the request is seen.
    bus.fetchReq  = 1'b1;
    bus.fetchAddr = 16'h0003;
    cyc  = 0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.fetchAck) seen = 1'b1;
    end
    chk("rdAckSeen",  102, {15'd0, seen}, 16'd1);
    chk("rdLatency",  102, 16'(cyc), 16'd2);
    chk("rdData",     102, bus.fetchData, 16'h1357);
    bus.fetchReq = 1'b0;
    @(posedge clk);
    #1;
    chk("rdAckPulse", 103, {15'd0, bus.fetchAck}, 16'd0);
    chk("rdDataHold", 103, bus.fetchData, 16'h1357);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
